// File: rtl/wb_ext_bridge_if.sv
// ---------------------------------------------------------------------------
// wb_ext_bridge_if
// Wishbone classic slave-port bundle between the caravel Wishbone pins and
// wb_ext_bridge.  Signal names keep the caravel naming, where the _i/_o
// suffixes are seen from the slave (bridge) side.
//
// Parameters:
//   ADDR_W  address width
//   DATA_W  data width (multiple of 8)
//
// Signals:
//   wbs_cyc_i, wbs_stb_i, wbs_we_i   cycle / strobe / write-enable
//   wbs_sel_i [DATA_W/8]             byte selects
//   wbs_adr_i [ADDR_W]               address
//   wbs_dat_i [DATA_W]               write data
//   wbs_dat_o [DATA_W]               read data (driven by the bridge)
//   wbs_ack_o                        acknowledge (driven by the bridge)
//
// Modports:
//   master  Wishbone host side (drives control, address, write data)
//   slave   bridge side (drives read data and ack)
// ---------------------------------------------------------------------------
interface wb_ext_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic                  wbs_we_i;
    logic [DATA_W/8-1:0]   wbs_sel_i;
    logic [ADDR_W-1:0]     wbs_adr_i;
    logic [DATA_W-1:0]     wbs_dat_i;
    logic [DATA_W-1:0]     wbs_dat_o;
    logic                  wbs_ack_o;

    modport master (
        output wbs_cyc_i,
        output wbs_stb_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_adr_i,
        output wbs_dat_i,
        input  wbs_dat_o,
        input  wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i,
        input  wbs_stb_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_adr_i,
        input  wbs_dat_i,
        output wbs_dat_o,
        output wbs_ack_o
    );

endinterface

// File: rtl/wb_ext_bridge.sv
// ---------------------------------------------------------------------------
// wb_ext_bridge
// Registered bridge from the caravel Wishbone classic slave port to NUM_CH
// core-side ext_* request/ready ports.  Every Wishbone transaction is run by
// a small FSM that decodes a channel from the address, raises ext_valid on
// that channel only, waits for ext_ready, captures read data and returns a
// single-cycle ack.  If the host drops cyc mid-request the core-side request
// is still carried through to ready, but no ack is returned.
//
// Optional feature (macro WB_EXT_TIMEOUT_EN):
//   A down-counter bounds the time spent waiting for ext_ready.  On expiry
//   the request is dropped, the host is acked with all-ones data and the
//   sticky timeout_irq is set; it clears on the next normally completed ack.
//   Without the macro the bridge waits indefinitely and timeout_irq is 0.
//
// Ports:
//   wb_clk_i          clock
//   wb_rst_i          synchronous active-high reset
//   wb                Wishbone slave bundle (wb_ext_bridge_if.slave)
//   ext_valid         per-channel request
//   ext_ready         per-channel completion
//   ext_address       per-channel address, channel c at [c*ADDR_W +: ADDR_W]
//   ext_write_data    per-channel write data
//   ext_write_strobe  per-channel byte strobes (zero for reads)
//   ext_instruction   per-channel instruction-space flag
//   ext_read_data     per-channel read data
//   timeout_irq       sticky timeout flag
//
// FSM states:
//   ST_IDLE | waiting for cyc & stb; latches the request
//   ST_REQ  | ext_valid high on the addressed channel until ready/timeout
//   ST_ACK  | wbs_ack_o high for this single cycle
// ---------------------------------------------------------------------------
module wb_ext_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_CH         = 2,
    parameter int CH_SEL_LSB     = 24,
    parameter int INSTR_BIT      = 23,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    wb_ext_bridge_if.slave                 wb,
    output logic [NUM_CH-1:0]              ext_valid,
    input  logic [NUM_CH-1:0]              ext_ready,
    output logic [NUM_CH*ADDR_W-1:0]       ext_address,
    output logic [NUM_CH*DATA_W-1:0]       ext_write_data,
    output logic [NUM_CH*(DATA_W/8)-1:0]   ext_write_strobe,
    output logic [NUM_CH-1:0]              ext_instruction,
    input  logic [NUM_CH*DATA_W-1:0]       ext_read_data,
    output logic                           timeout_irq
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SW = DATA_W / 8;
    // One extra bit so that channel numbers >= NUM_CH compare correctly
    // even when NUM_CH is a power of two.
    localparam logic [CW:0] NUM_CH_W = (CW + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                      state_q,  state_d;
    logic [CW-1:0]               ch_q,     ch_d;
    logic                        we_q,     we_d;
    logic                        miss_q,   miss_d;
    logic                        abort_q,  abort_d;
    logic [NUM_CH-1:0]           valid_q,  valid_d;
    logic [NUM_CH*ADDR_W-1:0]    addr_q,   addr_d;
    logic [NUM_CH*DATA_W-1:0]    wdata_q,  wdata_d;
    logic [NUM_CH*SW-1:0]        strb_q,   strb_d;
    logic [NUM_CH-1:0]           instr_q,  instr_d;
    logic [DATA_W-1:0]           dat_o_q,  dat_o_d;
    logic                        ack_q,    ack_d;

`ifdef WB_EXT_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0]               cnt_q,    cnt_d;
    logic                        irq_q,    irq_d;
    logic                        tmo;
`endif

    // Addressed-channel view of ext_ready / ext_read_data.
    logic                        rdy_sel;
    logic [DATA_W-1:0]           rd_sel;
    // Completion of the current REQ and the data returned to the host.
    logic                        done;
    logic [DATA_W-1:0]           rdata;

    always_comb begin
        rdy_sel = 1'b0;
        rd_sel  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CW'(c)) begin
                rdy_sel = ext_ready[c];
                rd_sel  = ext_read_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        we_d    = we_q;
        miss_d  = miss_q;
        abort_d = abort_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        instr_d = instr_q;
        dat_o_d = dat_o_q;
        ack_d   = 1'b0;
        done    = 1'b0;
        rdata   = '0;
`ifdef WB_EXT_TIMEOUT_EN
        cnt_d   = cnt_q;
        irq_d   = irq_q;
        tmo     = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
                    ch_d    = wb.wbs_adr_i[CH_SEL_LSB +: CW];
                    we_d    = wb.wbs_we_i;
                    abort_d = 1'b0;
                    miss_d  = ({1'b0, ch_d} >= NUM_CH_W);
                    state_d = ST_REQ;
`ifdef WB_EXT_TIMEOUT_EN
                    cnt_d   = TW'(TIMEOUT_CYCLES - 1);
`endif
                    // ext outputs are all zero in IDLE, so only the addressed
                    // channel needs loading.  An undecoded channel still spends
                    // one cycle in REQ with nothing driven, which keeps its
                    // stb-to-ack latency equal to the fastest real access.
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (!miss_d && ch_d == CW'(c)) begin
                            valid_d[c]                      = 1'b1;
                            addr_d[c*ADDR_W +: ADDR_W]      = wb.wbs_adr_i;
                            wdata_d[c*DATA_W +: DATA_W]     = wb.wbs_dat_i;
                            strb_d[c*SW +: SW]              = wb.wbs_we_i ? wb.wbs_sel_i : '0;
                            instr_d[c]                      = wb.wbs_adr_i[INSTR_BIT];
                        end
                    end
                end
            end

            ST_REQ: begin
                // Once cyc has dropped the host no longer wants the ack, but
                // the core-side handshake is still finished.
                abort_d = abort_q | ~wb.wbs_cyc_i;

                if (miss_q) begin
                    done = 1'b1;
                end else if (rdy_sel) begin
                    done  = 1'b1;
                    rdata = we_q ? '0 : rd_sel;
                end
`ifdef WB_EXT_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    done  = 1'b1;
                    tmo   = 1'b1;
                    rdata = '1;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
`endif

                if (done) begin
                    valid_d = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                    strb_d  = '0;
                    instr_d = '0;
                    if (abort_d) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        dat_o_d = rdata;
                    end
`ifdef WB_EXT_TIMEOUT_EN
                    if (tmo) begin
                        irq_d = 1'b1;
                    end else if (!abort_d) begin
                        irq_d = 1'b0;
                    end
`endif
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            we_q    <= 1'b0;
            miss_q  <= 1'b0;
            abort_q <= 1'b0;
            valid_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            instr_q <= '0;
            dat_o_q <= '0;
            ack_q   <= 1'b0;
`ifdef WB_EXT_TIMEOUT_EN
            cnt_q   <= '0;
            irq_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            we_q    <= we_d;
            miss_q  <= miss_d;
            abort_q <= abort_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            instr_q <= instr_d;
            dat_o_q <= dat_o_d;
            ack_q   <= ack_d;
`ifdef WB_EXT_TIMEOUT_EN
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
`endif
        end
    end

    assign ext_valid        = valid_q;
    assign ext_address      = addr_q;
    assign ext_write_data   = wdata_q;
    assign ext_write_strobe = strb_q;
    assign ext_instruction  = instr_q;
    assign wb.wbs_dat_o     = dat_o_q;
    assign wb.wbs_ack_o     = ack_q;

`ifdef WB_EXT_TIMEOUT_EN
    assign timeout_irq = irq_q;
`else
    assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ext_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_ext_bridge
// Directed bench for wb_ext_bridge with NUM_CH=3 (2-bit channel field, so
// channel 3 is an undecoded address) and TIMEOUT_CYCLES=8.
// ---------------------------------------------------------------------------
module tb_wb_ext_bridge;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_ext_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) wb_if ();

    logic [NCH-1:0]     ext_valid;
    logic [NCH-1:0]     ext_ready;
    logic [NCH*AW-1:0]  ext_address;
    logic [NCH*DW-1:0]  ext_write_data;
    logic [NCH*SW-1:0]  ext_write_strobe;
    logic [NCH-1:0]     ext_instruction;
    logic [NCH*DW-1:0]  ext_read_data;
    logic               timeout_irq;

    wb_ext_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH), .CH_SEL_LSB(24),
        .INSTR_BIT(23), .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .wb               (wb_if),
        .ext_valid        (ext_valid),
        .ext_ready        (ext_ready),
        .ext_address      (ext_address),
        .ext_write_data   (ext_write_data),
        .ext_write_strobe (ext_write_strobe),
        .ext_instruction  (ext_instruction),
        .ext_read_data    (ext_read_data),
        .timeout_irq      (timeout_irq)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          k;        // cycle in which ready is presented
        int          ch;
        logic        miss;
        logic [2:0]  noise;    // ready asserted on other channels throughout
        logic [31:0] exp_dat;
    } vec_t;

    // Drives one transaction starting at the current negedge (cycle 0) and
    // returns at the negedge of the cycle after the ack.
    task automatic run_vec(input vec_t v, input string tag);
        logic [NCH-1:0]    oh;
        logic [NCH*AW-1:0] e_adr;
        logic [NCH*DW-1:0] e_wd;
        logic [NCH*SW-1:0] e_st;
        logic [NCH-1:0]    e_in;
        logic [NCH-1:0]    e_val;
        int                ack_cyc;
        oh    = v.miss ? '0 : (NCH'(1) << v.ch);
        e_adr = '0;
        e_wd  = '0;
        e_st  = '0;
        e_in  = '0;
        if (!v.miss) begin
            e_adr[v.ch*AW +: AW] = v.adr;
            e_wd[v.ch*DW +: DW]  = v.wdata;
            e_st[v.ch*SW +: SW]  = v.we ? v.sel : 4'h0;
            e_in[v.ch]           = v.adr[23];
        end
        ack_cyc = v.miss ? 2 : v.k + 1;

        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_we_i  = v.we;
        wb_if.wbs_sel_i = v.sel;
        wb_if.wbs_adr_i = v.adr;
        wb_if.wbs_dat_i = v.wdata;
        ext_ready       = v.noise & ~oh;
        ext_read_data   = {NCH{32'hBAD0BAD0}};

        for (int n = 1; n <= ack_cyc; n++) begin
            @(negedge clk);
            e_val = (!v.miss && n <= v.k) ? oh : '0;
            chk({tag, " valid"}, ext_valid, e_val);
            chk({tag, " ack"}, wb_if.wbs_ack_o, (n == ack_cyc));
            if (n == 1) begin
                chk({tag, " address"}, ext_address, e_adr);
                chk({tag, " wdata"}, ext_write_data, e_wd);
                chk({tag, " strobe"}, ext_write_strobe, e_st);
                chk({tag, " instr"}, ext_instruction, e_in);
            end
            if (n == ack_cyc) begin
                chk({tag, " dat_o"}, wb_if.wbs_dat_o, v.exp_dat);
                wb_if.wbs_cyc_i = 1'b0;
                wb_if.wbs_stb_i = 1'b0;
                ext_ready       = '0;
            end else if (!v.miss && n == v.k) begin
                ext_ready                  = oh | (v.noise & ~oh);
                ext_read_data[v.ch*DW +: DW] = v.rdata;
            end
        end
        @(negedge clk);
        chk({tag, " ack_one_cycle"}, wb_if.wbs_ack_o, 1'b0);
    endtask

    vec_t vecs[6];
    vec_t post;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0010, 1'b0, 4'hF, 32'hDEAD_0000, 32'hCAFE_BABE, 3, 0, 1'b0, 3'b000, 32'hCAFE_BABE};
        vecs[1] = '{32'h0100_0004, 1'b1, 4'b0110, 32'h1122_3344, 32'h5555_5555, 2, 1, 1'b0, 3'b001, 32'h0000_0000};
        vecs[2] = '{32'h0280_0020, 1'b0, 4'hF, 32'h0000_0000, 32'h1357_9BDF, 1, 2, 1'b0, 3'b011, 32'h1357_9BDF};
        vecs[3] = '{32'h0300_0000, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b1, 3'b111, 32'h0000_0000};
        vecs[4] = '{32'h0080_00FC, 1'b1, 4'b1001, 32'hA5A5_5A5A, 32'h6666_6666, 1, 0, 1'b0, 3'b000, 32'h0000_0000};
        vecs[5] = '{32'h0100_0008, 1'b0, 4'hF, 32'h0000_0000, 32'h2468_ACE0, 2, 1, 1'b0, 3'b100, 32'h2468_ACE0};
        post    = '{32'h0000_0040, 1'b0, 4'hF, 32'h0000_0000, 32'h0F0F_0F0F, 1, 0, 1'b0, 3'b000, 32'h0F0F_0F0F};

        rst             = 1'b1;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_sel_i = '0;
        wb_if.wbs_adr_i = '0;
        wb_if.wbs_dat_i = '0;
        ext_ready       = '0;
        ext_read_data   = '0;
        repeat (3) @(negedge clk);

        chk("reset valid", ext_valid, '0);
        chk("reset ack", wb_if.wbs_ack_o, 1'b0);
        chk("reset dat_o", wb_if.wbs_dat_o, '0);
        chk("reset address", ext_address, '0);
        chk("reset strobe", ext_write_strobe, '0);
        chk("reset irq", timeout_irq, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort: cyc drops in REQ, ready arrives five cycles later.
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_adr_i = 32'h0100_0000;
        @(negedge clk);
        chk("abort valid_c1", ext_valid, 3'b010);
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
        for (int n = 2; n <= 6; n++) begin
            @(negedge clk);
            chk($sformatf("abort valid_c%0d", n), ext_valid, 3'b010);
            chk($sformatf("abort ack_c%0d", n), wb_if.wbs_ack_o, 1'b0);
        end
        ext_ready     = 3'b010;
        ext_read_data = {NCH{32'h7777_7777}};
        @(negedge clk);
        chk("abort valid_dropped", ext_valid, '0);
        chk("abort no_ack_c7", wb_if.wbs_ack_o, 1'b0);
        ext_ready = '0;
        @(negedge clk);
        chk("abort no_ack_c8", wb_if.wbs_ack_o, 1'b0);
        run_vec(post, "after_abort");

        // Reset during REQ with ready pending.
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_we_i  = 1'b1;
        wb_if.wbs_sel_i = 4'hF;
        wb_if.wbs_adr_i = 32'h0200_0000;
        wb_if.wbs_dat_i = 32'h9999_9999;
        @(negedge clk);
        chk("rstmid valid_c1", ext_valid, 3'b100);
        @(negedge clk);
        rst       = 1'b1;
        ext_ready = 3'b100;
        @(negedge clk);
        chk("rstmid valid", ext_valid, '0);
        chk("rstmid ack", wb_if.wbs_ack_o, 1'b0);
        chk("rstmid dat_o", wb_if.wbs_dat_o, '0);
        chk("rstmid address", ext_address, '0);
        chk("rstmid wdata", ext_write_data, '0);
        chk("rstmid strobe", ext_write_strobe, '0);
        rst             = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
        @(negedge clk);
        chk("rstmid ready_ignored_ack", wb_if.wbs_ack_o, 1'b0);
        chk("rstmid ready_ignored_valid", ext_valid, '0);
        ext_ready = '0;
        @(negedge clk);

`ifdef WB_EXT_TIMEOUT_EN
        // No ready: 8 REQ cycles, then ack with all-ones and irq set.
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_adr_i = 32'h0000_0010;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            chk($sformatf("tmo valid_c%0d", n), ext_valid, 3'b001);
            chk($sformatf("tmo ack_c%0d", n), wb_if.wbs_ack_o, 1'b0);
        end
        @(negedge clk);
        chk("tmo ack", wb_if.wbs_ack_o, 1'b1);
        chk("tmo dat_o", wb_if.wbs_dat_o, 32'hFFFF_FFFF);
        chk("tmo irq", timeout_irq, 1'b1);
        chk("tmo valid_dropped", ext_valid, '0);
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
        ext_ready       = 3'b001;
        @(negedge clk);
        ext_ready = '0;
        @(negedge clk);
        chk("tmo late_ready_no_ack", wb_if.wbs_ack_o, 1'b0);
        chk("tmo irq_sticky", timeout_irq, 1'b1);
        run_vec(post, "after_tmo");
        chk("tmo irq_cleared", timeout_irq, 1'b0);
`else
        chk("irq tied_low", timeout_irq, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
